// File: rtl/target_frame_receiver.sv
// rtl/target_frame_receiver.sv - 8N1 UART receiver that decodes machine-select frames
//
// Receives 8N1 bytes (LSB first, idle high) on rx.
// Each well-framed byte is interpreted as a target select (id 1..20), a clear (0x00) or an illegal id.
//
// Ports:
//   clk          system clock; all state updates on its rising edge
//   rst_n        asynchronous active-low reset
//   rx           asynchronous serial input
//   rx_byte      last byte received with a valid stop bit
//   byte_valid   one-cycle pulse when rx_byte updates
//   target_id    currently selected machine id (0 = none)
//   target_valid one-cycle pulse when target_id is loaded with a legal id
//   target_clear one-cycle pulse when a 0x00 frame clears target_id
//   id_err       one-cycle pulse on a well-framed byte that is neither a select nor 0x00
//   frame_err    one-cycle pulse when the stop bit samples low
module target_frame_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic [4:0] target_id,
  output logic       target_valid,
  output logic       target_clear,
  output logic       id_err,
  output logic       frame_err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [15:0] clk_cnt, cnt_next;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        rx_meta, rx_s;
  logic        sample_bit;
  logic        stop_ok;
  logic        stop_bad;
  logic        sel_ok;
  logic        is_zero;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= 16'd0;
    end else begin
      state   <= state_next;
      clk_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = clk_cnt;
    sample_bit = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = 16'd0;
        if (!rx_s) state_next = START;
      end
      START: begin
        // Re-check the line half a bit in so a short low glitch is dropped.
        if (clk_cnt == HALF_LAST) begin
          cnt_next   = 16'd0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = clk_cnt + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_next   = 16'd0;
          sample_bit = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          cnt_next = clk_cnt + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_next = 16'd0;
          if (rx_s) begin
            stop_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = clk_cnt + 16'd1;
        end
      end
      BREAK: begin
        // Line held low past the stop bit: wait for it to return high
        // so the tail of a break is not mistaken for a new start bit.
        cnt_next = 16'd0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = 16'd0;
        state_next = IDLE;
      end
    endcase
  end

  // Select frame: 0 b6..b2 1 1 with id in 1..20.
  assign sel_ok  = !shift_reg[7] && (shift_reg[1:0] == 2'b11) &&
                   (shift_reg[6:2] >= 5'd1) && (shift_reg[6:2] <= 5'd20);
  assign is_zero = (shift_reg == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx      <= 3'd0;
      shift_reg    <= 8'h00;
      rx_byte      <= 8'h00;
      target_id    <= 5'd0;
      byte_valid   <= 1'b0;
      target_valid <= 1'b0;
      target_clear <= 1'b0;
      id_err       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      byte_valid   <= 1'b0;
      target_valid <= 1'b0;
      target_clear <= 1'b0;
      id_err       <= 1'b0;
      frame_err    <= 1'b0;

      if (state == IDLE) bit_idx <= 3'd0;

      if (sample_bit) begin
        shift_reg[bit_idx] <= rx_s;
        bit_idx            <= bit_idx + 3'd1;
      end

      // Decode lands in the same cycle as byte_valid.
      if (stop_ok) begin
        rx_byte    <= shift_reg;
        byte_valid <= 1'b1;
        if (sel_ok) begin
          target_id    <= shift_reg[6:2];
          target_valid <= 1'b1;
        end else if (is_zero) begin
          target_id    <= 5'd0;
          target_clear <= 1'b1;
        end else begin
          id_err <= 1'b1;
        end
      end

      if (stop_bad) frame_err <= 1'b1;
    end
  end

endmodule
